bird_motion: RTL and testbench

Frame-rate physics engine for the player bird. Turns the flap button into a vertical position under constant gravity and tracks the game state: idle, flying or dead. Sits directly upstream of `bird_painter` and drives its `bx`/`by` inputs. Also exports a `dead` flag for the score and pipe logic.

---
 rtl/bird_pkg.sv | 17 +
 rtl/bird_motion_if.sv | 24 ++
 rtl/flap_edge_latch.sv | 41 ++++
 rtl/bird_motion.sv | 167 ++++++++++++++++
 tb/tb_bird_motion.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bird_pkg.sv
// Shared types and screen constants for the bird physics slice.
package bird_pkg;

    localparam int unsigned VEL_W  = 8;
    localparam int unsigned POS_W  = 11;
    localparam int unsigned CALC_W = 12;

    localparam int FLOOR_Y_DEF = 440;
    localparam int SCREEN_H    = 480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        DEAD = 2'd2
    } bird_state_t;

endpackage

// File: rtl/bird_motion_if.sv
// Game-facing signal bundle of bird_motion: frame/flap/hit in, bird pose and state out.
interface bird_motion_if;
    import bird_pkg::*;

    logic                     frame_tick;
    logic                     flap;
    logic                     hit;
    logic [POS_W-1:0]         bx;
    logic [POS_W-1:0]         by;
    logic signed [VEL_W-1:0]  vel;
    bird_state_t              state;
    logic                     dead;

    modport master (
        output frame_tick, flap, hit,
        input  bx, by, vel, state, dead
    );

    modport slave (
        input  frame_tick, flap, hit,
        output bx, by, vel, state, dead
    );

endinterface

// File: rtl/flap_edge_latch.sv
// Flap button front end: 2-FF synchroniser, rising-edge detect, per-frame pending latch.
// `pending` includes an edge seen in the current cycle so a press landing on the
// tick cycle is consumed by that tick.
module flap_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic flap,
    input  logic frame_tick,
    input  logic clear,
    output logic pending
);

    logic sync1;
    logic sync2;
    logic sync2_d;
    logic pending_q;
    logic rise;

    assign rise    = sync2 & ~sync2_d;
    assign pending = pending_q | rise;

    // Synchronise the button, then hold one press until the next tick consumes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync2_d   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            sync1   <= flap;
            sync2   <= sync1;
            sync2_d <= sync2;
            if (clear || frame_tick) begin
                pending_q <= 1'b0;
            end else if (rise) begin
                pending_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bird_motion.sv
// Frame-rate bird physics: flap/gravity integration, floor/ceiling limits, IDLE/FLY/DEAD.
// Build option BIRD_CEILING_KILL_EN: touching the ceiling kills the bird instead of
// acting as a soft wall.
module bird_motion
    import bird_pkg::*;
#(
    parameter int X_POS    = 200,
    parameter int START_Y  = 240,
    parameter int RADIUS   = 32,
    parameter int FLOOR_Y  = FLOOR_Y_DEF,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = 10,
    parameter int MAX_FALL = 12
) (
    input  logic          clk,
    input  logic          rst,
    bird_motion_if.slave  bus
);

    localparam logic signed [CALC_W-1:0] FLOOR_LIM  = CALC_W'(FLOOR_Y - RADIUS);
    localparam logic signed [CALC_W-1:0] CEIL_LIM   = CALC_W'(RADIUS);
    localparam logic signed [CALC_W-1:0] FLAP_V     = CALC_W'(-FLAP_VEL);
    localparam logic signed [CALC_W-1:0] FALL_MAX   = CALC_W'(MAX_FALL);
    localparam logic signed [CALC_W-1:0] GRAV       = CALC_W'(GRAVITY);
    localparam logic [POS_W-1:0]         START_POS  = POS_W'(START_Y);
    localparam logic [POS_W-1:0]         LAUNCH_POS = POS_W'(START_Y - FLAP_VEL);
    localparam logic [POS_W-1:0]         FLOOR_POS  = POS_W'(FLOOR_Y - RADIUS);
    localparam logic [POS_W-1:0]         CEIL_POS   = POS_W'(RADIUS);
    localparam logic [POS_W-1:0]         X_CENTRE   = POS_W'(X_POS);
    localparam logic signed [VEL_W-1:0]  LAUNCH_VEL = VEL_W'(-FLAP_VEL);

    bird_state_t              state_q;
    bird_state_t              state_d;
    logic [POS_W-1:0]         by_q;
    logic [POS_W-1:0]         by_d;
    logic signed [VEL_W-1:0]  vel_q;
    logic signed [VEL_W-1:0]  vel_d;
    logic                     dead_q;

    logic                     pending;
    logic                     clear;
    logic                     tick_fly;
    logic                     restart;
    logic signed [CALC_W-1:0] vel_grav;
    logic signed [CALC_W-1:0] v_next;
    logic signed [CALC_W-1:0] y_next;
    logic                     floor_hit;
    logic                     ceil_hit;

    flap_edge_latch u_flap (
        .clk        (clk),
        .rst        (rst),
        .flap       (bus.flap),
        .frame_tick (bus.frame_tick),
        .clear      (clear),
        .pending    (pending)
    );

    // A press racing the death transition is dropped so it cannot restart the game.
    assign clear    = (state_d == DEAD) && (state_q != DEAD);
    assign tick_fly = bus.frame_tick && !bus.hit;
    assign restart  = bus.frame_tick && pending;

    // Candidate velocity and position for the next frame, in 12-bit signed.
    always_comb begin
        vel_grav  = CALC_W'(vel_q) + GRAV;
        v_next    = pending ? FLAP_V : ((vel_grav > FALL_MAX) ? FALL_MAX : vel_grav);
        y_next    = $signed({1'b0, by_q}) + v_next;
        floor_hit = (y_next >= FLOOR_LIM);
        ceil_hit  = (y_next < CEIL_LIM);
    end

    // State register plus the pose registers that move with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            by_q    <= START_POS;
            vel_q   <= '0;
            dead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            by_q    <= by_d;
            vel_q   <= vel_d;
            dead_q  <= (state_d == DEAD);
        end
    end

    // Next-state logic; a hit in flight wins over a same-cycle tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (restart) begin
                    state_d = FLY;
                end
            end
            FLY: begin
                if (bus.hit) begin
                    state_d = DEAD;
                end else if (bus.frame_tick) begin
                    if (floor_hit) begin
                        state_d = DEAD;
                    end else if (ceil_hit) begin
`ifdef BIRD_CEILING_KILL_EN
                        state_d = DEAD;
`else
                        state_d = FLY;
`endif
                    end
                end
            end
            DEAD: begin
                if (restart) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next pose; frozen unless a tick moves the bird or a restart re-centres it.
    always_comb begin
        by_d  = by_q;
        vel_d = vel_q;
        case (state_q)
            IDLE: begin
                by_d  = START_POS;
                vel_d = '0;
                if (restart) begin
                    by_d  = LAUNCH_POS;
                    vel_d = LAUNCH_VEL;
                end
            end
            FLY: begin
                if (tick_fly) begin
                    if (floor_hit) begin
                        by_d  = FLOOR_POS;
                        vel_d = '0;
                    end else if (ceil_hit) begin
                        by_d  = CEIL_POS;
                        vel_d = '0;
                    end else begin
                        by_d  = y_next[POS_W-1:0];
                        vel_d = v_next[VEL_W-1:0];
                    end
                end
            end
            DEAD: begin
                if (restart) begin
                    by_d  = START_POS;
                    vel_d = '0;
                end
            end
            default: begin
                by_d  = START_POS;
                vel_d = '0;
            end
        endcase
    end

    assign bus.bx    = X_CENTRE;
    assign bus.by    = by_q;
    assign bus.vel   = vel_q;
    assign bus.state = state_q;
    assign bus.dead  = dead_q;

endmodule

// File: tb/tb_bird_motion.sv
// Self-checking bench for bird_motion against a frame-level behavioural model.
module tb_bird_motion;
    import bird_pkg::*;

    localparam int X_POS    = 200;
    localparam int START_Y  = 240;
    localparam int RADIUS   = 32;
    localparam int FLOOR_Y  = 440;
    localparam int GRAVITY  = 1;
    localparam int FLAP_VEL = 10;
    localparam int MAX_FALL = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bird_motion_if ifc ();

    bird_motion #(
        .X_POS(X_POS), .START_Y(START_Y), .RADIUS(RADIUS), .FLOOR_Y(FLOOR_Y),
        .GRAVITY(GRAVITY), .FLAP_VEL(FLAP_VEL), .MAX_FALL(MAX_FALL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   edge_cnt = 0;
    int   press_q[$];
    logic flap_prev = 1'b0;

    // Model: 0 idle, 1 flying, 2 dead; y and v as plain integers.
    int m_state = 0;
    int m_y     = START_Y;
    int m_v     = 0;

    // A press counts for any tick sampled at or after its eligible edge.
    function automatic bit has_pending(input int e);
        foreach (press_q[i]) if (press_q[i] <= e) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drop_upto(input int e);
        int keep[$];
        foreach (press_q[i]) if (press_q[i] > e) keep.push_back(press_q[i]);
        press_q = keep;
    endtask

    task automatic model_reset();
        m_state = 0; m_y = START_Y; m_v = 0;
        press_q.delete();
    endtask

    task automatic model_edge(input logic tk, input logic ht);
        int e;
        bit pend;
        int was;
        int nv;
        int ny;
        e    = edge_cnt;
        pend = has_pending(e);
        was  = m_state;
        if (m_state == 0) begin
            if (tk && pend) begin m_state = 1; m_y = START_Y - FLAP_VEL; m_v = -FLAP_VEL; end
        end else if (m_state == 1) begin
            if (ht) m_state = 2;
            else if (tk) begin
                nv = pend ? -FLAP_VEL : ((m_v + GRAVITY > MAX_FALL) ? MAX_FALL : m_v + GRAVITY);
                ny = m_y + nv;
                if (ny >= FLOOR_Y - RADIUS) begin
                    m_y = FLOOR_Y - RADIUS; m_v = 0; m_state = 2;
                end else if (ny < RADIUS) begin
                    m_y = RADIUS; m_v = 0;
`ifdef BIRD_CEILING_KILL_EN
                    m_state = 2;
`endif
                end else begin
                    m_y = ny; m_v = nv;
                end
            end
        end else begin
            if (tk && pend) begin m_state = 0; m_y = START_Y; m_v = 0; end
        end
        if (tk) drop_upto(e);
        if (m_state == 2 && was != 2) drop_upto(e);
    endtask

    // One clock: drive on the falling edge, advance the model on the rising edge, settle.
    task automatic cyc(input logic tk, input logic ht, input logic fl);
        @(negedge clk);
        if (fl && !flap_prev) press_q.push_back(edge_cnt + 3);
        flap_prev      = fl;
        ifc.flap       = fl;
        ifc.frame_tick = tk;
        ifc.hit        = ht;
        @(posedge clk);
        edge_cnt++;
        model_edge(tk, ht);
        #1;
    endtask

    // A frame of len cycles ending in a tick; optional single-cycle press at press_at.
    task automatic frame(input int len, input int press_at, input logic hit_on_tick);
        for (int c = 0; c < len - 1; c++) cyc(1'b0, 1'b0, c == press_at);
        cyc(1'b1, hit_on_tick, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.flap = 1'b0; ifc.frame_tick = 1'b0; ifc.hit = 1'b0;
        repeat (2) begin @(posedge clk); edge_cnt++; end
        #1;
        model_reset();
        n_checks++;
        if ({ifc.state, ifc.by, ifc.vel, ifc.dead, ifc.bx} !== {IDLE, 11'd240, 8'd0, 1'b0, 11'd200}) begin
            n_errors++;
            $display("FAIL reset_state: got st=%0d by=%0d vel=%0d dead=%0b bx=%0d exp st=0 by=240 vel=0 dead=0 bx=200",
                     ifc.state, ifc.by, ifc.vel, ifc.dead, ifc.bx);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_launch();
        frame(4, 0, 1'b0);
        n_checks++;
        if ({ifc.state, ifc.by, ifc.vel} !== {FLY, 11'd230, -8'sd10}) begin
            n_errors++;
            $display("FAIL launch: got st=%0d by=%0d vel=%0d exp st=1 by=230 vel=-10",
                     ifc.state, ifc.by, ifc.vel);
        end
        frame(4, -1, 1'b0);
        n_checks++;
        if ({ifc.state, ifc.by, ifc.vel} !== {FLY, 11'd221, -8'sd9}) begin
            n_errors++;
            $display("FAIL first_gravity: got st=%0d by=%0d vel=%0d exp st=1 by=221 vel=-9",
                     ifc.state, ifc.by, ifc.vel);
        end
    endtask

    task automatic test_reset_mid_flight();
        frame(4, -1, 1'b0);
        frame(4, -1, 1'b0);
        n_checks++;
        if ({ifc.state, ifc.by, ifc.vel} !== {2'(m_state), 11'(m_y), 8'(m_v)}) begin
            n_errors++;
            $display("FAIL pre_reset_flight: got st=%0d by=%0d vel=%0d exp st=%0d by=%0d vel=%0d",
                     ifc.state, ifc.by, ifc.vel, m_state, m_y, m_v);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if ({ifc.state, ifc.by, ifc.vel, ifc.dead} !== {IDLE, 11'd240, 8'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL async_reset: got st=%0d by=%0d vel=%0d dead=%0b exp st=0 by=240 vel=0 dead=0",
                     ifc.state, ifc.by, ifc.vel, ifc.dead);
        end
        rst = 1'b0;
    endtask

    task automatic test_gravity_floor();
        int  budget;
        bit  saw_max;
        frame(4, 0, 1'b0);
        budget  = 60;
        saw_max = 1'b0;
        while (m_state == 1 && budget > 0) begin
            frame(3, -1, 1'b0);
            budget--;
            if (m_v == MAX_FALL && ifc.vel == 8'sd12) saw_max = 1'b1;
            n_checks++;
            if ({ifc.state, ifc.by, ifc.vel, ifc.dead} !== {2'(m_state), 11'(m_y), 8'(m_v), m_state == 2}) begin
                n_errors++;
                $display("FAIL fall_step: got st=%0d by=%0d vel=%0d dead=%0b exp st=%0d by=%0d vel=%0d",
                         ifc.state, ifc.by, ifc.vel, ifc.dead, m_state, m_y, m_v);
            end
        end
        n_checks++;
        if ({ifc.state, ifc.by, ifc.vel, ifc.dead, saw_max} !== {DEAD, 11'd408, 8'd0, 1'b1, 1'b1}) begin
            n_errors++;
            $display("FAIL floor_death: got st=%0d by=%0d vel=%0d dead=%0b saw12=%0b exp st=2 by=408 vel=0 dead=1 saw12=1",
                     ifc.state, ifc.by, ifc.vel, ifc.dead, saw_max);
        end
        frame(4, 0, 1'b0);
        n_checks++;
        if ({ifc.state, ifc.by, ifc.vel, ifc.dead} !== {IDLE, 11'd240, 8'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL restart: got st=%0d by=%0d vel=%0d dead=%0b exp st=0 by=240 vel=0 dead=0",
                     ifc.state, ifc.by, ifc.vel, ifc.dead);
        end
    endtask

    task automatic test_hit();
        logic [10:0] y0;
        logic [7:0]  v0;
        frame(4, 0, 1'b0);
        frame(4, -1, 1'b0);
        y0 = 11'(m_y);
        v0 = 8'(m_v);
        frame(4, -1, 1'b1);
        n_checks++;
        if ({ifc.state, ifc.by, ifc.vel, ifc.dead} !== {DEAD, y0, v0, 1'b1}) begin
            n_errors++;
            $display("FAIL hit_freeze: got st=%0d by=%0d vel=%0d dead=%0b exp st=2 by=%0d vel=%0d dead=1",
                     ifc.state, ifc.by, ifc.vel, ifc.dead, y0, $signed(v0));
        end
        frame(4, 0, 1'b0);
        n_checks++;
        if ({ifc.state, ifc.by} !== {IDLE, 11'd240}) begin
            n_errors++;
            $display("FAIL hit_restart: got st=%0d by=%0d exp st=0 by=240", ifc.state, ifc.by);
        end
    endtask

    task automatic test_merge_and_late();
        frame(4, 0, 1'b0);
        frame(4, -1, 1'b0);
        for (int c = 0; c < 7; c++) cyc(1'b0, 1'b0, c == 0 || c == 3);
        cyc(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (ifc.vel !== -8'sd10 || ifc.by !== 11'(m_y)) begin
            n_errors++;
            $display("FAIL double_press: got by=%0d vel=%0d exp by=%0d vel=-10", ifc.by, ifc.vel, m_y);
        end
        frame(4, -1, 1'b0);
        n_checks++;
        if (ifc.vel !== -8'sd9) begin
            n_errors++;
            $display("FAIL press_merge: got vel=%0d exp vel=-9", ifc.vel);
        end
        for (int c = 0; c < 4; c++) cyc(1'b0, 1'b0, c == 3);
        cyc(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (ifc.vel !== -8'sd8 || ifc.by !== 11'(m_y)) begin
            n_errors++;
            $display("FAIL late_press_this_tick: got by=%0d vel=%0d exp by=%0d vel=-8", ifc.by, ifc.vel, m_y);
        end
        frame(4, -1, 1'b0);
        n_checks++;
        if (ifc.vel !== -8'sd10 || ifc.by !== 11'(m_y)) begin
            n_errors++;
            $display("FAIL late_press_next_tick: got by=%0d vel=%0d exp by=%0d vel=-10", ifc.by, ifc.vel, m_y);
        end
    endtask

    task automatic test_ceiling();
        int budget;
        budget = 40;
        while (m_state == 1 && m_y - FLAP_VEL >= RADIUS && budget > 0) begin
            frame(4, 0, 1'b0);
            budget--;
        end
        frame(4, 0, 1'b0);
        n_checks++;
`ifdef BIRD_CEILING_KILL_EN
        if ({ifc.state, ifc.by, ifc.vel, ifc.dead} !== {DEAD, 11'd32, 8'd0, 1'b1}) begin
            n_errors++;
            $display("FAIL ceiling: got st=%0d by=%0d vel=%0d dead=%0b exp st=2 by=32 vel=0 dead=1",
                     ifc.state, ifc.by, ifc.vel, ifc.dead);
        end
`else
        if ({ifc.state, ifc.by, ifc.vel, ifc.dead} !== {FLY, 11'd32, 8'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL ceiling: got st=%0d by=%0d vel=%0d dead=%0b exp st=1 by=32 vel=0 dead=0",
                     ifc.state, ifc.by, ifc.vel, ifc.dead);
        end
`endif
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        frame(4, 0, 1'b0);
        n_checks++;
        if ({ifc.state, ifc.by, ifc.vel, ifc.dead} !== {IDLE, 11'd240, 8'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL ceiling_restart: got st=%0d by=%0d vel=%0d dead=%0b exp st=0 by=240 vel=0 dead=0",
                     ifc.state, ifc.by, ifc.vel, ifc.dead);
        end
    endtask

    task automatic test_random();
        int   left;
        logic tk;
        logic fl;
        logic ht;
        left = $urandom_range(3, 6);
        for (int i = 0; i < 600; i++) begin
            left--;
            tk = (left == 0);
            if (tk) left = $urandom_range(3, 6);
            fl = !flap_prev && ($urandom_range(0, 4) == 0);
            ht = ($urandom_range(0, 59) == 0);
            cyc(tk, ht, fl);
            n_checks++;
            if ({ifc.state, ifc.by, ifc.vel, ifc.dead, ifc.bx} !==
                {2'(m_state), 11'(m_y), 8'(m_v), m_state == 2, 11'd200}) begin
                n_errors++;
                $display("FAIL random_cycle_%0d: got st=%0d by=%0d vel=%0d dead=%0b bx=%0d exp st=%0d by=%0d vel=%0d",
                         i, ifc.state, ifc.by, ifc.vel, ifc.dead, ifc.bx, m_state, m_y, m_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_launch();
        test_reset_mid_flight();
        test_gravity_floor();
        test_hit();
        test_merge_and_late();
        test_ceiling();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
